// File: rtl/trace_capture.sv
// trace_capture: per-player stroke capture stage for the 4x4 rune grid.
//
// Debounced direction buttons move a cursor over the grid (cell = row*4 + col).
// While the draw button is held, every visited cell is ORed into a 16-bit
// traced mask. The mask is cleared whenever the displayed target rune changes,
// and both the mask and the cursor are restored when the trace screen closes.
//
// Optional feature macro: TRACE_CURSOR_WRAP_EN
//   defined   -> moves off a grid edge wrap within the same row/column
//   undefined -> moves off a grid edge are ignored (cursor saturates)
//
// Parameters:
//   START_CELL    cursor cell after reset, screen entry and screen exit
//   MOVE_HOLDOFF  auto-repeat period in cycles for a held direction, 0 = off
//
// Ports:
//   clk              system clock
//   resetn           asynchronous active-low reset
//   trace_screen_on  trace screen active
//   btn_up/down/left/right  debounced direction levels
//   btn_draw         pen-down level
//   target           rune currently displayed
//   traced           accumulated cell mask (registered)
//   cursor           current cell (registered)
//   drawing          high while in DRAW (registered)
//   stroke_done      one-cycle pulse after a pen lift (registered)
module trace_capture #(
  parameter int START_CELL   = 0,
  parameter int MOVE_HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trace_screen_on,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_draw,
  input  logic [15:0] target,
  output logic [15:0] traced,
  output logic [3:0]  cursor,
  output logic        drawing,
  output logic        stroke_done
);

`ifdef TRACE_CURSOR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // A zero holdoff still needs a one-bit counter to keep the declarations legal.
  localparam int HW = (MOVE_HOLDOFF < 1) ? 1 : $clog2(MOVE_HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MOVE_HOLDOFF);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MOVE_HOLDOFF - 1);
  localparam logic [3:0]    START_C   = 4'(START_CELL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AIM   = 2'd1,
    S_DRAW  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     traced_q, traced_d;
  logic [15:0]     prev_target_q, prev_target_d;
  logic [3:0]      cursor_q, cursor_d;
  logic            drawing_q, drawing_d;
  logic            stroke_q, stroke_d;
  logic [3:0]      btn_prev_q;
  logic [3:0]      dir_q;
  logic [HW-1:0]   hold_q, hold_d;

  logic [3:0]      btn_vec_s;
  logic [3:0]      sel_s;
  logic            rise_s;
  logic            rpt_s;
  logic            move_s;
  logic            tchg_s;
  logic [3:0]      moved_s;
  logic [15:0]     cur_bit_s;

  // Direction vector bit order: [0]=up [1]=down [2]=left [3]=right.
  assign btn_vec_s = {btn_right, btn_left, btn_down, btn_up};
  assign tchg_s    = (target != prev_target_q);
  assign cur_bit_s = 16'd1 << cursor_q;

  // Priority-select the single acting direction.
  always_comb begin
    sel_s = 4'b0000;
    if (btn_up) begin
      sel_s = 4'b0001;
    end else if (btn_down) begin
      sel_s = 4'b0010;
    end else if (btn_left) begin
      sel_s = 4'b0100;
    end else if (btn_right) begin
      sel_s = 4'b1000;
    end else begin
      sel_s = 4'b0000;
    end
  end

  // A move fires on a fresh press of the selected direction, or when the same
  // direction has been held for a full holdoff period since the last move.
  assign rise_s = |(sel_s & ~btn_prev_q);
  assign rpt_s  = (MOVE_HOLDOFF != 0) && (sel_s != 4'b0000) &&
                  (sel_s == dir_q) && (hold_q >= HOLD_LAST);
  assign move_s = rise_s | rpt_s;

  // Holdoff counter: restart on any move or direction change, else saturate.
  always_comb begin
    hold_d = hold_q;
    if (move_s || (sel_s != dir_q)) begin
      hold_d = '0;
    end else if (hold_q < HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  // Candidate cursor after applying the selected move with edge handling.
  always_comb begin
    moved_s = cursor_q;
    if (move_s) begin
      case (sel_s)
        4'b0001: moved_s = (cursor_q[3:2] == 2'd0) ? (WRAP_EN ? cursor_q + 4'd12 : cursor_q)
                                                   : cursor_q - 4'd4;
        4'b0010: moved_s = (cursor_q[3:2] == 2'd3) ? (WRAP_EN ? cursor_q - 4'd12 : cursor_q)
                                                   : cursor_q + 4'd4;
        4'b0100: moved_s = (cursor_q[1:0] == 2'd0) ? (WRAP_EN ? cursor_q + 4'd3 : cursor_q)
                                                   : cursor_q - 4'd1;
        4'b1000: moved_s = (cursor_q[1:0] == 2'd3) ? (WRAP_EN ? cursor_q - 4'd3 : cursor_q)
                                                   : cursor_q + 4'd1;
        default: moved_s = cursor_q;
      endcase
    end else begin
      moved_s = cursor_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: screen exit beats target change, which beats draw.
  always_comb begin
    state_d = state_q;
    if (!trace_screen_on) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_AIM;
        S_AIM:   state_d = tchg_s ? S_CLEAR : (btn_draw ? S_DRAW : S_AIM);
        S_DRAW:  state_d = tchg_s ? S_CLEAR : (btn_draw ? S_DRAW : S_AIM);
        S_CLEAR: state_d = S_AIM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values; the current cell is marked before moving.
  always_comb begin
    traced_d      = traced_q;
    cursor_d      = cursor_q;
    prev_target_d = prev_target_q;
    stroke_d      = 1'b0;
    drawing_d     = (state_d == S_DRAW);
    if (!trace_screen_on) begin
      traced_d = 16'h0000;
      cursor_d = START_C;
      if (state_q == S_IDLE) begin
        prev_target_d = target;
      end else begin
        prev_target_d = prev_target_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          traced_d      = 16'h0000;
          cursor_d      = START_C;
          prev_target_d = target;
        end
        S_AIM: begin
          if (tchg_s) begin
            prev_target_d = target;
          end else begin
            cursor_d = moved_s;
            traced_d = btn_draw ? (traced_q | cur_bit_s) : traced_q;
          end
        end
        S_DRAW: begin
          if (tchg_s) begin
            prev_target_d = target;
          end else if (!btn_draw) begin
            stroke_d = 1'b1;
            cursor_d = moved_s;
          end else begin
            traced_d = traced_q | cur_bit_s;
            cursor_d = moved_s;
          end
        end
        S_CLEAR: traced_d = 16'h0000;
        default: begin
          traced_d = 16'h0000;
          cursor_d = START_C;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      traced_q      <= 16'h0000;
      cursor_q      <= START_C;
      drawing_q     <= 1'b0;
      stroke_q      <= 1'b0;
      prev_target_q <= 16'h0000;
      btn_prev_q    <= 4'b0000;
      dir_q         <= 4'b0000;
      hold_q        <= '0;
    end else begin
      traced_q      <= traced_d;
      cursor_q      <= cursor_d;
      drawing_q     <= drawing_d;
      stroke_q      <= stroke_d;
      prev_target_q <= prev_target_d;
      btn_prev_q    <= btn_vec_s;
      dir_q         <= sel_s;
      hold_q        <= hold_d;
    end
  end

  assign traced      = traced_q;
  assign cursor      = cursor_q;
  assign drawing     = drawing_q;
  assign stroke_done = stroke_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: stimulus queues expected cursor/mask
// states (stamped with the cycle they must appear) and expected stroke pulses;
// a separate monitor pops and compares them as the design presents outputs.
module tb_trace_capture;

`ifdef TRACE_CURSOR_WRAP_EN
  localparam logic [3:0] UP_EXP   = 4'd12;
  localparam logic [3:0] LEFT_EXP = 4'd15;
`else
  localparam logic [3:0] UP_EXP   = 4'd0;
  localparam logic [3:0] LEFT_EXP = 4'd0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        trace_screen_on;
  logic        btn_up, btn_down, btn_left, btn_right, btn_draw;
  logic [15:0] target;
  logic [15:0] traced;
  logic [3:0]  cursor;
  logic        drawing;
  logic        stroke_done;

  trace_capture #(.START_CELL(0), .MOVE_HOLDOFF(4)) dut (
    .clk(clk), .resetn(resetn), .trace_screen_on(trace_screen_on),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_draw(btn_draw), .target(target),
    .traced(traced), .cursor(cursor), .drawing(drawing),
    .stroke_done(stroke_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] tr;
    logic [3:0]  cu;
    logic        dr;
    string       nm;
  } exp_t;

  typedef struct {
    logic [15:0] tr;
    logic [3:0]  cu;
    string       nm;
  } stk_t;

  exp_t expq[$];
  stk_t stkq[$];
  exp_t me;
  stk_t ms;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  // Expect this state after the coming clock edge.
  task automatic expect_state(input string nm, input logic [15:0] tr,
                              input logic [3:0] cu, input logic dr);
    exp_t e;
    e.cyc = cyc + 1;
    e.tr  = tr;
    e.cu  = cu;
    e.dr  = dr;
    e.nm  = nm;
    expq.push_back(e);
  endtask

  task automatic expect_stroke(input string nm, input logic [15:0] tr,
                               input logic [3:0] cu);
    stk_t s;
    s.tr = tr;
    s.cu = cu;
    s.nm = nm;
    stkq.push_back(s);
  endtask

  // Monitor: compare queued states at their cycle, and every stroke pulse.
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      me = expq.pop_front();
      n_total++;
      if (me.cyc != cyc) begin
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", me.nm, cyc, me.cyc);
      end else if (traced !== me.tr || cursor !== me.cu || drawing !== me.dr) begin
        $display("FAIL %s: got traced=%h cursor=%0d drawing=%b, want traced=%h cursor=%0d drawing=%b",
                 me.nm, traced, cursor, drawing, me.tr, me.cu, me.dr);
      end else begin
        n_pass++;
      end
    end
    if (stroke_done !== 1'b0) begin
      n_total++;
      if (stkq.size() == 0) begin
        $display("FAIL stroke_unexpected: got stroke_done=%b at cycle %0d, want 0", stroke_done, cyc);
      end else begin
        ms = stkq.pop_front();
        if (traced !== ms.tr || cursor !== ms.cu) begin
          $display("FAIL %s: got traced=%h cursor=%0d, want traced=%h cursor=%0d",
                   ms.nm, traced, cursor, ms.tr, ms.cu);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic set_dir(input logic u, input logic d, input logic l, input logic r);
    btn_up    = u;
    btn_down  = d;
    btn_left  = l;
    btn_right = r;
  endtask

  initial begin
    resetn          = 1'b0;
    trace_screen_on = 1'b0;
    set_dir(1'b0, 1'b0, 1'b0, 1'b0);
    btn_draw        = 1'b0;
    target          = 16'h0000;

    // Reset held with inputs toggling.
    for (int i = 0; i < 3; i++) begin
      tick();
      set_dir(i[0], ~i[0], i[1], ~i[0]);
      btn_draw        = ~i[0];
      trace_screen_on = i[0];
      expect_state("reset", 16'h0000, 4'd0, 1'b0);
    end
    tick();
    resetn          = 1'b1;
    trace_screen_on = 1'b0;
    set_dir(1'b0, 1'b0, 1'b0, 1'b0);
    btn_draw        = 1'b0;
    expect_state("idle_after_reset", 16'h0000, 4'd0, 1'b0);

    // Stroke across the top row with three right pulses.
    tick(); trace_screen_on = 1'b1; btn_draw = 1'b1;
    expect_state("screen_on_aim", 16'h0000, 4'd0, 1'b0);
    tick(); expect_state("draw_first_bit", 16'h0001, 4'd0, 1'b1);
    tick(); btn_right = 1'b1; expect_state("r1_move", 16'h0001, 4'd1, 1'b1);
    tick(); btn_right = 1'b0; expect_state("r1_mark", 16'h0003, 4'd1, 1'b1);
    tick(); btn_right = 1'b1; expect_state("r2_move", 16'h0003, 4'd2, 1'b1);
    tick(); btn_right = 1'b0; expect_state("r2_mark", 16'h0007, 4'd2, 1'b1);
    tick(); btn_right = 1'b1; expect_state("r3_move", 16'h0007, 4'd3, 1'b1);
    tick(); btn_right = 1'b0; expect_state("r3_mark", 16'h000F, 4'd3, 1'b1);
    tick(); btn_draw = 1'b0;
    expect_state("pen_lift", 16'h000F, 4'd3, 1'b0);
    expect_stroke("stroke_row0", 16'h000F, 4'd3);
    tick(); expect_state("aim_after_lift", 16'h000F, 4'd3, 1'b0);
    tick(); trace_screen_on = 1'b0; expect_state("exit_aim", 16'h0000, 4'd0, 1'b0);

    // Grid-edge moves from cell 0.
    tick(); trace_screen_on = 1'b1; expect_state("aim_edge", 16'h0000, 4'd0, 1'b0);
    tick(); btn_up = 1'b1; expect_state("up_at_row0", 16'h0000, UP_EXP, 1'b0);
    tick(); btn_up = 1'b0; btn_left = 1'b1; expect_state("left_at_col0", 16'h0000, LEFT_EXP, 1'b0);
    tick(); btn_left = 1'b0; expect_state("edge_hold", 16'h0000, LEFT_EXP, 1'b0);
    tick(); trace_screen_on = 1'b0; expect_state("exit_edge", 16'h0000, 4'd0, 1'b0);

    // Auto-repeat: right held for 10 cycles moves at cycles 0, 4 and 8.
    tick(); trace_screen_on = 1'b1; expect_state("aim_rpt", 16'h0000, 4'd0, 1'b0);
    tick(); btn_right = 1'b1; expect_state("rpt_c0", 16'h0000, 4'd1, 1'b0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      expect_state("rpt_hold", 16'h0000, (k <= 4) ? 4'd1 : ((k <= 8) ? 4'd2 : 4'd3), 1'b0);
    end
    tick(); btn_right = 1'b0; expect_state("rpt_release", 16'h0000, 4'd3, 1'b0);

    // Draw 0x0231 (cells 0,4,5,9), then change target with draw held.
    tick(); trace_screen_on = 1'b0; target = 16'h0231;
    expect_state("exit_rpt", 16'h0000, 4'd0, 1'b0);
    tick(); trace_screen_on = 1'b1; expect_state("aim_tchg", 16'h0000, 4'd0, 1'b0);
    tick(); btn_draw = 1'b1; expect_state("tc_c0", 16'h0001, 4'd0, 1'b1);
    tick(); btn_down = 1'b1; expect_state("tc_down", 16'h0001, 4'd4, 1'b1);
    tick(); btn_down = 1'b0; btn_right = 1'b1; expect_state("tc_right", 16'h0011, 4'd5, 1'b1);
    tick(); btn_right = 1'b0; btn_down = 1'b1; expect_state("tc_down2", 16'h0031, 4'd9, 1'b1);
    tick(); btn_down = 1'b0; expect_state("tc_mask", 16'h0231, 4'd9, 1'b1);
    tick(); target = 16'h0075; expect_state("tchg_edge1", 16'h0231, 4'd9, 1'b0);
    tick(); expect_state("tchg_edge2", 16'h0000, 4'd9, 1'b0);
    tick(); expect_state("tchg_edge3", 16'h0200, 4'd9, 1'b1);

    // Screen exit together with pen lift: no stroke pulse.
    tick(); trace_screen_on = 1'b0; btn_draw = 1'b0;
    expect_state("exit_with_lift", 16'h0000, 4'd0, 1'b0);

    // Draw 0x00F0 (cells 4..7) and drop the screen mid-stroke.
    tick(); trace_screen_on = 1'b1; expect_state("aim_mid", 16'h0000, 4'd0, 1'b0);
    tick(); btn_down = 1'b1; expect_state("aim_down", 16'h0000, 4'd4, 1'b0);
    tick(); btn_down = 1'b0; btn_draw = 1'b1; expect_state("mid_c4", 16'h0010, 4'd4, 1'b1);
    tick(); btn_right = 1'b1; expect_state("mid_m5", 16'h0010, 4'd5, 1'b1);
    tick(); btn_right = 1'b0; expect_state("mid_s5", 16'h0030, 4'd5, 1'b1);
    tick(); btn_right = 1'b1; expect_state("mid_m6", 16'h0030, 4'd6, 1'b1);
    tick(); btn_right = 1'b0; expect_state("mid_s6", 16'h0070, 4'd6, 1'b1);
    tick(); btn_right = 1'b1; expect_state("mid_m7", 16'h0070, 4'd7, 1'b1);
    tick(); btn_right = 1'b0; expect_state("mid_mask", 16'h00F0, 4'd7, 1'b1);
    tick(); trace_screen_on = 1'b0; expect_state("exit_mid_stroke", 16'h0000, 4'd0, 1'b0);
    tick(); btn_draw = 1'b0; expect_state("idle_hold", 16'h0000, 4'd0, 1'b0);

    tick();
    tick();
    while (expq.size() > 0) begin
      me = expq.pop_front();
      n_total++;
      $display("FAIL %s: never checked, required at cycle %0d", me.nm, me.cyc);
    end
    while (stkq.size() > 0) begin
      ms = stkq.pop_front();
      n_total++;
      $display("FAIL %s: got no stroke_done pulse, want one", ms.nm);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Per-player stroke capture stage. It converts debounced direction and draw buttons into a cursor on the 4x4 rune grid and accumulates the cells visited while the draw button is held. The result is a 16-bit traced mask. One instance per player drives `p1_traced` / `p2_traced` of the trace-matching stage. The block clears its mask whenever the displayed target changes, so a stale stroke never matches the next rune.

## Interface
Parameters:
- `START_CELL`, 0: cursor cell (0..15) after reset, screen entry and screen exit; cell = row*4 + col, bit index = cell.
- `MOVE_HOLDOFF`, 4: auto-repeat period in cycles while a direction stays held; 0 disables repeat.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `trace_screen_on`  in  1  trace screen active.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced levels, synchronous to `clk`.
- `btn_draw`  in  1  pen-down level.
- `target`  in  16  rune currently displayed (`trace_to_display`).
- `traced`  out  16  accumulated cell mask.
- `cursor`  out  4  current cell.
- `drawing`  out  1  high in DRAW.
- `stroke_done`  out  1  one-cycle pulse on pen lift.

## Operation
- FSM states:
  - IDLE: `traced`=0, `cursor`=START_CELL, `prev_target`<=`target` every cycle. Moves to AIM when `trace_screen_on`=1.
  - AIM: cursor moves, no bits set. If `btn_draw`=1, set bit `cursor` and go to DRAW.
  - DRAW: each edge, set bit of the current (pre-move) `cursor`, then apply any move. If `btn_draw`=0, go to AIM and pulse `stroke_done`; no bit is set on that edge.
  - CLEAR: one cycle. `traced`<=0, then AIM.
- Target change: in AIM or DRAW, `target`≠`prev_target` → `prev_target`<=`target`, state CLEAR, `drawing`=0, no `stroke_done`. This takes priority over draw and move on that edge.
- Screen exit: `trace_screen_on`=0 in any state → IDLE on the next edge. `traced` and `cursor` are restored, no `stroke_done`. This takes priority over everything except reset.
- Moves:
  - Only one direction acts per edge; priority up > down > left > right.
  - A move fires on the rising edge of the selected direction.
  - While that direction stays held, it repeats every MOVE_HOLDOFF cycles. The holdoff counter restarts on every accepted edge-move, and when the held direction changes.
- Edge behaviour: up at row 0, down at row 3, left at col 0 and right at col 3 leave `cursor` unchanged.
- `traced` only ORs bits in; bits are removed only by CLEAR, IDLE or reset.

## Timing
- Reset values: `traced`=0, `cursor`=START_CELL, `drawing`=0, `stroke_done`=0, state IDLE, `prev_target`=0, holdoff counter 0.
- All outputs are registered.
- A bit for a cell appears in `traced` one edge after `cursor` shows that cell while in DRAW.
- `stroke_done` is high for exactly the cycle after DRAW exits on pen lift.
- `traced` reads 0 on the second edge after a `target` change (edge 1: detect → CLEAR; edge 2: cleared).
- Screen-on to first possible bit: 2 edges (IDLE→AIM, AIM→DRAW sets the bit).
- Holdoff counter width: $clog2(MOVE_HOLDOFF+1); it saturates and does not wrap.

## Configuration
- `TRACE_CURSOR_WRAP_EN` defined: moves at a grid edge wrap within the same row or column.
  - up at cell 1 → 13
  - right at cell 7 → 4
- `TRACE_CURSOR_WRAP_EN` undefined: edge moves are ignored (saturate).

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with buttons toggling → `traced`=16'h0000, `cursor`=0, `drawing`=0, `stroke_done`=0 throughout.
- Screen on, hold `btn_draw`, pulse `btn_right` 3 times (1 cycle each, 2 cycles apart), release draw → `traced`=16'h000F, `cursor`=3, a single `stroke_done` pulse.
- Cursor at 0, pulse `btn_up` → `cursor` stays 0; with `TRACE_CURSOR_WRAP_EN`, `cursor`=12.
- Draw `traced`=16'h0231, then change `target` 16'h0231→16'h0075 with draw held → `drawing` falls on edge 1, `traced`=0 after edge 2, no `stroke_done`, DRAW re-entered on edge 3.
- MOVE_HOLDOFF=4, cursor 0, hold `btn_right` 10 cycles in AIM → moves at cycles 0, 4 and 8; `cursor`=3, `traced` stays 0.
- Drop `trace_screen_on` mid-stroke with `traced`=16'h00F0 → next edge `traced`=0, `cursor`=START_CELL, `drawing`=0, no `stroke_done`.
